// File: rtl/fp_accumulator_if.sv
// Handshake bundle for fp_accumulator.
// Both channels use strict valid/ready: a beat transfers on a rising edge where
// valid and ready are both high; once valid is raised its payload stays stable
// until that edge, and ready never depends combinationally on valid.
interface fp_accumulator_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic [W-1:0] acc_data;
    logic [2:0]   fsm_state;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, acc_data, fsm_state
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf, acc_data, fsm_state
    );
endinterface

// File: rtl/fp_accumulator.sv
// Sequential floating-point accumulator. Each accepted operand walks through
// ALIGN, ADD and NORM (one clock each) and is folded into the running sum;
// the operand tagged last releases the total on the output channel.
module fp_accumulator #(
    parameter int EXP_W     = 5,
    parameter int MAN_W     = 10,
    parameter int ROUND_RNE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    fp_accumulator_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;   // mantissa including hidden bit
    localparam int XW = MAN_W + 4;   // mantissa plus guard/round/sticky
    localparam int EW = EXP_W + 1;   // internal exponent with carry headroom
    localparam logic [EW-1:0] EXP_ONES = EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

    state_t        state;
    logic [W-1:0]  acc, out_data_r;
    logic          ovf, out_ovf_r, out_valid_r, in_ready_r;

    // latched operand
    logic          op_s, op_sat, op_last;
    logic [EW-1:0] op_e;
    logic [MW-1:0] op_m;
    // align stage results
    logic [XW-1:0] al_a, al_b;
    logic [EW-1:0] al_e;
    logic          al_s, al_sub;
    // add stage results
    logic [XW:0]   ad_sum;
    logic [EW-1:0] ad_e;
    logic          ad_s;

    // Unpack the incoming operand; an all-ones exponent clamps to max finite.
    logic [EXP_W-1:0] in_ef;
    logic [EW-1:0]    in_e;
    logic [MW-1:0]    in_m;
    logic             in_sat;
    always_comb begin
        in_ef  = bus.in_data[W-2 -: EXP_W];
        in_sat = (in_ef == '1);
        if (in_sat) begin
            in_e = EXP_ONES - EW'(1);
            in_m = '1;
        end else begin
            in_e = (in_ef == '0) ? EW'(1) : {1'b0, in_ef};
            in_m = {(in_ef != '0), bus.in_data[MAN_W-1:0]};
        end
    end

    // Pick the larger magnitude as base and right-shift the other with sticky.
    logic [EXP_W-1:0] acc_ef;
    logic [EW-1:0]    acc_e, diff;
    logic [MW-1:0]    acc_m, big_m, sml_m;
    logic [XW-1:0]    sml_x, sml_sh;
    logic             op_big;
    always_comb begin
        acc_ef = acc[W-2 -: EXP_W];
        acc_e  = (acc_ef == '0) ? EW'(1) : {1'b0, acc_ef};
        acc_m  = {(acc_ef != '0), acc[MAN_W-1:0]};
        op_big = {op_e, op_m} >= {acc_e, acc_m};
        big_m  = op_big ? op_m : acc_m;
        sml_m  = op_big ? acc_m : op_m;
        diff   = op_big ? (op_e - acc_e) : (acc_e - op_e);
        sml_x  = {sml_m, 3'b000};
        if (int'(diff) >= XW) begin
            sml_sh    = '0;
            sml_sh[0] = |sml_m;
        end else begin
            sml_sh    = sml_x >> diff;
            sml_sh[0] = sml_sh[0] | (|(sml_x & ~({XW{1'b1}} << diff)));
        end
    end

    // Magnitude add or subtract; the base is never smaller, so no borrow.
    logic [XW:0] sum_c;
    always_comb begin
        sum_c = al_sub ? ({1'b0, al_a} - {1'b0, al_b})
                       : ({1'b0, al_a} + {1'b0, al_b});
    end

    // Normalise, round, renormalise on rounding carry, then saturate.
    logic [XW-1:0] nm;
    logic [EW-1:0] ne;
    logic [MW-1:0] keep, man;
    logic [MW:0]   rnd;
    logic          inc, res_sat;
    logic [W-1:0]  res;
    int            lz, sh;
    always_comb begin
        lz = XW;
        for (int i = 0; i < XW; i++) begin
            if (ad_sum[i]) lz = XW - 1 - i;
        end
        sh = 0;
        if (ad_sum[XW]) begin
            nm    = ad_sum[XW:1];
            nm[0] = nm[0] | ad_sum[0];
            ne    = ad_e + EW'(1);
        end else begin
            // never shift the exponent below 1; what is left is subnormal
            sh = (lz > int'(ad_e) - 1) ? int'(ad_e) - 1 : lz;
            nm = ad_sum[XW-1:0] << sh;
            ne = ad_e - EW'(sh);
        end
        keep = nm[XW-1:3];
        inc  = (ROUND_RNE != 0) && nm[2] && (nm[1] || nm[0] || keep[0]);
        rnd  = {1'b0, keep} + {{MW{1'b0}}, inc};
        if (rnd[MW]) begin
            man = rnd[MW:1];
            ne  = ne + EW'(1);
        end else begin
            man = rnd[MW-1:0];
        end
        res_sat = (ne >= EXP_ONES);
        if (res_sat) begin
            res = {ad_s, EXP_ONES[EXP_W-1:0] - EXP_W'(1), {MAN_W{1'b1}}};
        end else begin
            res = {ad_s, (man[MAN_W] ? ne[EXP_W-1:0] : {EXP_W{1'b0}}), man[MAN_W-1:0]};
        end
    end

    // Control FSM and all datapath/output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            acc         <= '0;
            ovf         <= 1'b0;
            out_data_r  <= '0;
            out_ovf_r   <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            op_s        <= 1'b0;
            op_sat      <= 1'b0;
            op_last     <= 1'b0;
            op_e        <= '0;
            op_m        <= '0;
            al_a        <= '0;
            al_b        <= '0;
            al_e        <= '0;
            al_s        <= 1'b0;
            al_sub      <= 1'b0;
            ad_sum      <= '0;
            ad_e        <= '0;
            ad_s        <= 1'b0;
        end else if (clr) begin
            state       <= S_IDLE;
            acc         <= '0;
            ovf         <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_s       <= bus.in_data[W-1];
                        op_e       <= in_e;
                        op_m       <= in_m;
                        op_sat     <= in_sat;
                        op_last    <= bus.in_last;
                        in_ready_r <= 1'b0;
                        state      <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    al_a   <= {big_m, 3'b000};
                    al_b   <= sml_sh;
                    al_e   <= op_big ? op_e : acc_e;
                    al_s   <= op_big ? op_s : acc[W-1];
                    al_sub <= op_s ^ acc[W-1];
                    state  <= S_ADD;
                end
                S_ADD: begin
                    ad_sum <= sum_c;
                    ad_e   <= al_e;
                    ad_s   <= (sum_c == '0) ? 1'b0 : al_s;
                    state  <= S_NORM;
                end
                S_NORM: begin
                    if (op_last) begin
                        out_data_r  <= res;
                        out_ovf_r   <= ovf | op_sat | res_sat;
                        out_valid_r <= 1'b1;
                        acc         <= '0;
                        ovf         <= 1'b0;
                        state       <= S_OUT;
                    end else begin
                        acc        <= res;
                        ovf        <= ovf | op_sat | res_sat;
                        in_ready_r <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    in_ready_r <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.acc_data  = acc;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_fp_accumulator.sv
// Directed plus light random bench for fp_accumulator (FP16). Two instances run
// in lockstep on the same stimulus: one rounding to nearest-even, one truncating.
module tb_fp_accumulator;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    fp_accumulator_if #(.W(W)) bus ();
    fp_accumulator_if #(.W(W)) bus_t ();

    fp_accumulator #(.EXP_W(5), .MAN_W(10), .ROUND_RNE(1)) dut_rne (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus.slave)
    );
    fp_accumulator #(.EXP_W(5), .MAN_W(10), .ROUND_RNE(0)) dut_trn (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_t.slave)
    );

    assign bus_t.in_valid  = bus.in_valid;
    assign bus_t.in_data   = bus.in_data;
    assign bus_t.in_last   = bus.in_last;
    assign bus_t.out_ready = bus.out_ready;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard: {ovf, rne_sum, trn_sum}
    logic [2*W:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [W-1:0] rne, input logic [W-1:0] trn, input logic ov);
        exp_q.push_back({ov, rne, trn});
    endtask

    // driver: called at a negedge, returns at the negedge after the accept edge
    task automatic send(input logic [W-1:0] d, input logic last);
        int cnt = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("send_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic compare_result(input string tag);
        logic [2*W:0] e;
        check({tag, "_q_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_rne_data"}, 32'(bus.out_data), 32'(e[2*W-1:W]));
            check({tag, "_trn_data"}, 32'(bus_t.out_data), 32'(e[W-1:0]));
            check({tag, "_rne_ovf"}, 32'(bus.out_ovf), 32'(e[2*W]));
            check({tag, "_trn_ovf"}, 32'(bus_t.out_ovf), 32'(e[2*W]));
        end
    endtask

    task automatic collect(input string tag);
        wait_valid(tag);
        compare_result(tag);
        @(negedge clk);
        check({tag, "_released"}, 32'(bus.out_valid), 32'd0);
    endtask

    // reference for small positive integers (exact in FP16)
    function automatic logic [15:0] int_to_h(input int v);
        int p = 0;
        for (int i = 0; i < 11; i++) begin
            if (v >= (1 << i)) p = i;
        end
        return {1'b0, 5'(15 + p), 10'((v << (10 - p)) & 'h3FF)};
    endfunction

    initial begin
        int total;
        int t;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        check("rst_acc", 32'(bus.acc_data), 32'd0);
        check("rst_state", 32'(bus.fsm_state), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1.0 + 2.0 with latency and acc_data tracking
        send(16'h3C00, 1'b0);
        repeat (2) @(negedge clk);
        check("t1_acc_before_norm", 32'(bus.acc_data), 32'h0000);
        @(negedge clk);
        check("t1_acc_after_norm", 32'(bus.acc_data), 32'h3C00);
        push(16'h4200, 16'h4200, 1'b0);
        send(16'h4000, 1'b1);
        repeat (2) @(negedge clk);
        check("t1_valid_early", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_on_time", 32'(bus.out_valid), 32'd1);
        compare_result("t1");
        check("t1_acc_cleared", 32'(bus.acc_data), 32'h0000);
        @(negedge clk);
        check("t1_released", 32'(bus.out_valid), 32'd0);
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);

        // cancellation to +0, subnormals, negative result
        push(16'h0000, 16'h0000, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'hBC00, 1'b1);
        collect("t2_cancel");
        push(16'h0002, 16'h0002, 1'b0);
        send(16'h0001, 1'b0);
        send(16'h0001, 1'b1);
        collect("t2_subnorm");
        push(16'hBC00, 16'hBC00, 1'b0);
        send(16'hC000, 1'b0);
        send(16'h3C00, 1'b1);
        collect("t2_negative");

        // saturation, ovf cleared for next sum, infinity input clamps
        push(16'h7BFF, 16'h7BFF, 1'b1);
        send(16'h7BFF, 1'b0);
        send(16'h7BFF, 1'b1);
        collect("t3_sat");
        push(16'h3C00, 16'h3C00, 1'b0);
        send(16'h3C00, 1'b1);
        collect("t3_ovf_clear");
        push(16'h7BFF, 16'h7BFF, 1'b1);
        send(16'h7C00, 1'b1);
        collect("t3_inf_in");

        // rounding mode difference on a tie-to-odd guard bit
        push(16'h3C02, 16'h3C01, 1'b0);
        send(16'h3C01, 1'b0);
        send(16'h1000, 1'b1);
        collect("t4_round");

        // random small-integer sums (exact in both modes)
        for (int k = 0; k < 4; k++) begin
            total = 0;
            for (int j = 0; j < 3; j++) begin
                t = $urandom_range(1, 100);
                total += t;
                if (j == 2) begin
                    push(int_to_h(total), int_to_h(total), 1'b0);
                end
                send(int_to_h(t), (j == 2));
            end
            collect("rand_sum");
        end

        // output back-pressure with a pending operand
        bus.out_ready = 1'b0;
        push(16'h3C00, 16'h3C00, 1'b0);
        send(16'h3C00, 1'b1);
        wait_valid("t5");
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h4000;
        bus.in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t5_hold_data", 32'(bus.out_data), 32'h3C00);
            check("t5_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        check("t5_acc_untouched", 32'(bus.acc_data), 32'h0000);
        compare_result("t5");
        bus.out_ready = 1'b1;
        push(16'h4000, 16'h4000, 1'b0);
        send(16'h4000, 1'b1);
        collect("t5_after");

        // clr during ADD discards the op
        send(16'h3C00, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t6_clr_state", 32'(bus.fsm_state), 32'd0);
        check("t6_clr_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("t6_clr_acc", 32'(bus.acc_data), 32'h0000);
        check("t6_clr_no_valid", 32'(bus.out_valid), 32'd0);

        // clr beats a same-cycle in_valid
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h3C00;
        bus.in_last  = 1'b1;
        @(negedge clk);
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("t6_clr_prio_ready", 32'(bus.in_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("t6_clr_prio_valid", 32'(bus.out_valid), 32'd0);
        check("t6_clr_prio_acc", 32'(bus.acc_data), 32'h0000);

        // asynchronous reset during NORM of a last operand
        send(16'h4400, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", 32'(bus.fsm_state), 32'd0);
        check("t6_rst_acc", 32'(bus.acc_data), 32'h0000);
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_rst_no_valid", 32'(bus.out_valid), 32'd0);
        push(16'h4000, 16'h4000, 1'b0);
        send(16'h4000, 1'b1);
        collect("t6_after");

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
